// File: rtl/axi_tdd_ng_counter.sv
// TDD timing core: IDLE/ARMED/WAITING/RUNNING sequencer with frame and burst counting.
// Strobes are computed from next-cycle values so they line up with the counter they describe.
module axi_tdd_ng_counter #(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tdd_enable,
  input  logic                         tdd_sync_rst,
  input  logic                         tdd_sync,
  input  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
  input  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
  output logic [REGISTER_WIDTH-1:0]    tdd_counter,
  output logic [1:0]                   tdd_cstate,
  output logic                         tdd_endof_frame,
  output logic                         tdd_endof_burst
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_WAITING = 2'b10,
    ST_RUNNING = 2'b11
  } state_t;

  state_t                       r_state;
  logic [REGISTER_WIDTH-1:0]    r_counter;
  logic [BURST_COUNT_WIDTH-1:0] r_frame_cnt;
  logic [REGISTER_WIDTH-1:0]    r_delay;
  logic [REGISTER_WIDTH-1:0]    r_frame_len;
  logic [BURST_COUNT_WIDTH-1:0] r_burst;
  logic                         r_endof_frame;
  logic                         r_endof_burst;

  state_t                       w_state_nxt;
  logic [REGISTER_WIDTH-1:0]    w_counter_nxt;
  logic [BURST_COUNT_WIDTH-1:0] w_frame_cnt_nxt;
  logic [REGISTER_WIDTH-1:0]    w_delay_nxt;
  logic [REGISTER_WIDTH-1:0]    w_frame_len_nxt;
  logic [BURST_COUNT_WIDTH-1:0] w_burst_nxt;
  logic                         w_trigger;
  logic                         w_eof_now;
  logic                         w_burst_end_now;
  logic                         w_eof_nxt;
  logic                         w_eob_nxt;

  assign w_trigger = tdd_sync &&
                     ((r_state == ST_ARMED) ||
                      (tdd_sync_rst && (r_state == ST_WAITING || r_state == ST_RUNNING)));

  assign w_eof_now       = (r_state == ST_RUNNING) && (r_counter == r_frame_len);
  assign w_burst_end_now = w_eof_now && (r_burst != '0) &&
                           (r_frame_cnt == r_burst - BURST_COUNT_WIDTH'(1));

  // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt     = r_state;
    w_counter_nxt   = r_counter;
    w_frame_cnt_nxt = r_frame_cnt;
    w_delay_nxt     = r_delay;
    w_frame_len_nxt = r_frame_len;
    w_burst_nxt     = r_burst;

    if (!tdd_enable) begin
      w_state_nxt     = ST_IDLE;
      w_counter_nxt   = '0;
      w_frame_cnt_nxt = '0;
    end else if (w_trigger) begin
      w_delay_nxt     = tdd_startup_delay;
      w_frame_len_nxt = tdd_frame_length;
      w_burst_nxt     = tdd_burst_count;
      w_counter_nxt   = '0;
      w_frame_cnt_nxt = '0;
      w_state_nxt     = (tdd_startup_delay != '0) ? ST_WAITING : ST_RUNNING;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt   = ST_ARMED;
          w_counter_nxt = '0;
        end
        ST_ARMED: w_counter_nxt = '0;
        ST_WAITING: begin
          if (r_counter == r_delay - REGISTER_WIDTH'(1)) begin
            w_state_nxt   = ST_RUNNING;
            w_counter_nxt = '0;
          end else begin
            w_counter_nxt = r_counter + REGISTER_WIDTH'(1);
          end
        end
        ST_RUNNING: begin
          if (w_eof_now) begin
            w_counter_nxt = '0;
            // Saturate so an infinite burst never aliases back onto a small count
            if (r_frame_cnt != '1)
              w_frame_cnt_nxt = r_frame_cnt + BURST_COUNT_WIDTH'(1);
            if (w_burst_end_now)
              w_state_nxt = ST_ARMED;
          end else begin
            w_counter_nxt = r_counter + REGISTER_WIDTH'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_eof_nxt = (w_state_nxt == ST_RUNNING) && (w_counter_nxt == w_frame_len_nxt);
  assign w_eob_nxt = w_eof_nxt && (w_burst_nxt != '0) &&
                     (w_frame_cnt_nxt == w_burst_nxt - BURST_COUNT_WIDTH'(1));

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_counter     <= '0;
      r_frame_cnt   <= '0;
      r_delay       <= '0;
      r_frame_len   <= '0;
      r_burst       <= '0;
      r_endof_frame <= 1'b0;
      r_endof_burst <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_counter     <= w_counter_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_delay       <= w_delay_nxt;
      r_frame_len   <= w_frame_len_nxt;
      r_burst       <= w_burst_nxt;
      r_endof_frame <= w_eof_nxt;
      r_endof_burst <= w_eob_nxt;
    end
  end

  assign tdd_counter     = r_counter;
  assign tdd_cstate      = r_state;
  assign tdd_endof_frame = r_endof_frame;
  assign tdd_endof_burst = r_endof_burst;

endmodule

// File: tb/tb_axi_tdd_ng_counter.sv
// Directed bench for axi_tdd_ng_counter: burst, zero delay, resync, disable, shadowing, zero-length frames.
module tb_axi_tdd_ng_counter;

  localparam int RW = 32;
  localparam int BW = 32;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ARM  = 2'b01;
  localparam logic [1:0] S_WAIT = 2'b10;
  localparam logic [1:0] S_RUN  = 2'b11;

  logic          clk;
  logic          rst;
  logic          tdd_enable;
  logic          tdd_sync_rst;
  logic          tdd_sync;
  logic [RW-1:0] tdd_startup_delay;
  logic [RW-1:0] tdd_frame_length;
  logic [BW-1:0] tdd_burst_count;
  logic [RW-1:0] tdd_counter;
  logic [1:0]    tdd_cstate;
  logic          tdd_endof_frame;
  logic          tdd_endof_burst;

  int n_cmp = 0;
  int n_err = 0;

  axi_tdd_ng_counter #(.REGISTER_WIDTH(RW), .BURST_COUNT_WIDTH(BW)) dut (
    .clk               (clk),
    .rst               (rst),
    .tdd_enable        (tdd_enable),
    .tdd_sync_rst      (tdd_sync_rst),
    .tdd_sync          (tdd_sync),
    .tdd_startup_delay (tdd_startup_delay),
    .tdd_frame_length  (tdd_frame_length),
    .tdd_burst_count   (tdd_burst_count),
    .tdd_counter       (tdd_counter),
    .tdd_cstate        (tdd_cstate),
    .tdd_endof_frame   (tdd_endof_frame),
    .tdd_endof_burst   (tdd_endof_burst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [1:0] st, input logic [RW-1:0] cnt,
                            input logic eof, input logic eob);
    check({tag, ".cstate"},  64'(tdd_cstate),      64'(st));
    check({tag, ".counter"}, 64'(tdd_counter),     64'(cnt));
    check({tag, ".eof"},     64'(tdd_endof_frame), 64'(eof));
    check({tag, ".eob"},     64'(tdd_endof_burst), 64'(eob));
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sync(input logic with_rst);
    tdd_sync_rst = with_rst;
    tdd_sync     = 1'b1;
    cyc();
    tdd_sync     = 1'b0;
    tdd_sync_rst = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    tdd_enable        = 1'b0;
    tdd_sync_rst      = 1'b0;
    tdd_sync          = 1'b0;
    tdd_startup_delay = '0;
    tdd_frame_length  = '0;
    tdd_burst_count   = '0;
    cyc();
    cyc();
    expect_all("reset", S_IDLE, 0, 1'b0, 1'b0);
    rst = 1'b0;

    // Sync while IDLE (disabled) is ignored
    tdd_sync = 1'b1;
    cyc();
    tdd_sync = 1'b0;
    check("idle_sync_ignored", 64'(tdd_cstate), 64'(S_IDLE));

    // Basic burst: delay 3, frame 4, burst 2
    tdd_startup_delay = 3;
    tdd_frame_length  = 4;
    tdd_burst_count   = 2;
    tdd_enable        = 1'b1;
    cyc();
    expect_all("armed", S_ARM, 0, 1'b0, 1'b0);
    pulse_sync(1'b0);
    expect_all("wait0", S_WAIT, 0, 1'b0, 1'b0);
    cyc();
    expect_all("wait1", S_WAIT, 1, 1'b0, 1'b0);
    cyc();
    expect_all("wait2", S_WAIT, 2, 1'b0, 1'b0);
    cyc();
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 5; c++) begin
        expect_all($sformatf("burst.f%0d.c%0d", f, c), S_RUN, RW'(c), c == 4, (c == 4) && (f == 1));
        cyc();
      end
    end
    expect_all("burst_done", S_ARM, 0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUNNING at counter 7
    tdd_startup_delay = 0;
    tdd_frame_length  = 9;
    tdd_burst_count   = 0;
    pulse_sync(1'b0);
    for (int i = 0; i < 7; i++) cyc();
    check("pre_rst_counter", 64'(tdd_counter), 64'd7);
    rst = 1'b1;
    #1;
    expect_all("async_rst", S_IDLE, 0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    cyc();
    expect_all("rearmed", S_ARM, 0, 1'b0, 1'b0);

    // Zero delay, infinite burst: 100 frames of 10 cycles
    pulse_sync(1'b0);
    for (int f = 0; f < 100; f++) begin
      for (int c = 0; c < 10; c++) begin
        expect_all($sformatf("inf.f%0d.c%0d", f, c), S_RUN, RW'(c), c == 9, 1'b0);
        cyc();
      end
    end
    expect_all("inf_still_running", S_RUN, 0, 1'b0, 1'b0);

    // Resync ignored without sync_rst, honoured with it (and burst relatched)
    for (int i = 0; i < 5; i++) cyc();
    check("resync_at5", 64'(tdd_counter), 64'd5);
    pulse_sync(1'b0);
    expect_all("resync_ignored", S_RUN, 6, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc();
    check("resync_at5b", 64'(tdd_counter), 64'd5);
    tdd_burst_count = 2;
    pulse_sync(1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 10; c++) begin
        expect_all($sformatf("resync.f%0d.c%0d", f, c), S_RUN, RW'(c), c == 9, (c == 9) && (f == 1));
        cyc();
      end
    end
    expect_all("resync_burst_done", S_ARM, 0, 1'b0, 1'b0);

    // Trigger on the end-of-frame cycle wins and relatches a shorter frame
    tdd_frame_length = 4;
    tdd_burst_count  = 0;
    pulse_sync(1'b0);
    for (int i = 0; i < 4; i++) cyc();
    expect_all("eof_before_trig", S_RUN, 4, 1'b1, 1'b0);
    tdd_frame_length = 2;
    pulse_sync(1'b1);
    expect_all("trig_wins", S_RUN, 0, 1'b0, 1'b0);
    cyc();
    cyc();
    expect_all("new_frame_eof", S_RUN, 2, 1'b1, 1'b0);

    // Shadowing: frame 4 latched, input moved to 20 afterwards
    tdd_frame_length = 4;
    pulse_sync(1'b1);
    tdd_frame_length = 20;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 5; c++) begin
        expect_all($sformatf("shadow.f%0d.c%0d", f, c), S_RUN, RW'(c), c == 4, 1'b0);
        cyc();
      end
    end

    // Disable sampled on the edge that would start the end-of-frame cycle
    for (int i = 0; i < 3; i++) cyc();
    check("dis_at3", 64'(tdd_counter), 64'd3);
    tdd_enable = 1'b0;
    cyc();
    expect_all("disabled", S_IDLE, 0, 1'b0, 1'b0);
    tdd_enable = 1'b1;
    cyc();
    expect_all("reenabled", S_ARM, 0, 1'b0, 1'b0);

    // Zero-length frames with burst 3
    tdd_frame_length = 0;
    tdd_burst_count  = 3;
    pulse_sync(1'b0);
    expect_all("zero.0", S_RUN, 0, 1'b1, 1'b0);
    cyc();
    expect_all("zero.1", S_RUN, 0, 1'b1, 1'b0);
    cyc();
    expect_all("zero.2", S_RUN, 0, 1'b1, 1'b1);
    cyc();
    expect_all("zero_done", S_ARM, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
